// File: rtl/mixer_n_seq.sv
// ---------------------------------------------------------------------------
// mixer_n_seq
//   Time-multiplexed N-channel audio mixer. A strobe latches one frame of
//   CHANNELS signed samples and their unsigned gains; the frame is summed
//   with one multiply-accumulate per clock, rescaled by the gain's fractional
//   bits (floor), saturated to the sample width and registered onto out.
//
// Ports
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   sample_in    one-cycle strobe, new input frame valid
//   in           packed signed samples, channel i = in[i*BITSIZE +: BITSIZE]
//   gain         packed unsigned gains, channel i = gain[i*GAINBITS +: GAINBITS]
//   out          registered signed mixed sample (held between results)
//   out_valid    one-cycle pulse when out updates
//   clip         high with out_valid when the result saturated
//   busy         high while a frame is in progress
//   sample_drop  one-cycle pulse after a strobe that arrived while busy
// ---------------------------------------------------------------------------
module mixer_n_seq #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 4,
    parameter int GAINBITS = 8,
    parameter int GAINFRAC = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         sample_in,
    input  logic [CHANNELS*BITSIZE-1:0]  in,
    input  logic [CHANNELS*GAINBITS-1:0] gain,
    output logic signed [BITSIZE-1:0]    out,
    output logic                         out_valid,
    output logic                         clip,
    output logic                         busy,
    output logic                         sample_drop
);

    localparam int PRODW = BITSIZE + GAINBITS + 1;
    // Room for CHANNELS worst-case products, so the sum can never wrap.
    localparam int ACCW  = PRODW + $clog2(CHANNELS);
    localparam int IDXW  = $clog2(CHANNELS);

    localparam logic signed [ACCW-1:0] MAXV = ACCW'((2 ** (BITSIZE - 1)) - 1);
    localparam logic signed [ACCW-1:0] MINV = -MAXV - ACCW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CHANNELS*BITSIZE-1:0]  in_q;
    logic [CHANNELS*GAINBITS-1:0] gain_q;
    logic signed [ACCW-1:0]       acc;
    logic [IDXW-1:0]              idx;

    logic signed [BITSIZE-1:0]    sel_in;
    logic [GAINBITS-1:0]          sel_gain;
    logic signed [PRODW-1:0]      prod;
    logic                         last_ch;
    logic signed [ACCW-1:0]       shifted;
    logic signed [BITSIZE-1:0]    sat;
    logic                         sat_clip;

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (sample_in) state_next = ACCUM;
            ACCUM:   if (last_ch)   state_next = OUTPUT;
            OUTPUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != IDLE);
    end

    // ---------------- datapath: one MAC per clock ----------------
    always_comb begin
        sel_in   = in_q[int'(idx)*BITSIZE +: BITSIZE];
        sel_gain = gain_q[int'(idx)*GAINBITS +: GAINBITS];
        // Gain is zero-extended so it multiplies as a non-negative signed value.
        prod     = PRODW'(sel_in) * PRODW'($signed({1'b0, sel_gain}));
        last_ch  = (idx == IDXW'(CHANNELS - 1));
    end

    // Rescale with arithmetic shift (floor toward -inf), then saturate.
    always_comb begin
        shifted  = acc >>> GAINFRAC;
        sat      = shifted[BITSIZE-1:0];
        sat_clip = 1'b0;
        if (shifted > MAXV) begin
            sat      = MAXV[BITSIZE-1:0];
            sat_clip = 1'b1;
        end else if (shifted < MINV) begin
            sat      = MINV[BITSIZE-1:0];
            sat_clip = 1'b1;
        end
    end

    // NOTE: the frame latches are small registers, so they take the async
    // reset like all other state; a reset can never leak an old frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_q        <= '0;
            gain_q      <= '0;
            acc         <= '0;
            idx         <= '0;
            out         <= '0;
            clip        <= 1'b0;
            out_valid   <= 1'b0;
            sample_drop <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            // Any strobe outside IDLE is discarded; the running frame is untouched.
            sample_drop <= sample_in && busy;
            unique case (state)
                IDLE: begin
                    if (sample_in) begin
                        in_q   <= in;
                        gain_q <= gain;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + ACCW'(prod);
                    idx <= idx + IDXW'(1);
                end
                OUTPUT: begin
                    out       <= sat;
                    clip      <= sat_clip;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mixer_n_seq.sv
// ---------------------------------------------------------------------------
// tb_mixer_n_seq
//   Self-checking bench for mixer_n_seq at default parameters. A frame-level
//   model (integer mix, floor, clamp, plus a schedule of when each accepted
//   frame is due) is compared against the DUT on every falling edge; directed
//   sequences additionally pin literal results, latency and strobe handling.
// ---------------------------------------------------------------------------
module tb_mixer_n_seq;

    localparam int BITSIZE  = 16;
    localparam int CHANNELS = 4;
    localparam int GAINBITS = 8;
    localparam int GAINFRAC = 6;
    localparam int LAT      = CHANNELS + 1;   // accept edge -> out_valid edge
    localparam int SPACING  = CHANNELS + 2;   // minimum strobe spacing

    logic                         clk = 1'b0;
    logic                         rstn = 1'b1;
    logic                         sample_in;
    logic [CHANNELS*BITSIZE-1:0]  in_v;
    logic [CHANNELS*GAINBITS-1:0] gain_v;
    logic signed [BITSIZE-1:0]    out;
    logic                         out_valid;
    logic                         clip;
    logic                         busy;
    logic                         sample_drop;

    int checks   = 0;
    int failures = 0;
    bit armed    = 0;

    mixer_n_seq #(
        .BITSIZE (BITSIZE),
        .CHANNELS(CHANNELS),
        .GAINBITS(GAINBITS),
        .GAINFRAC(GAINFRAC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sample_in  (sample_in),
        .in         (in_v),
        .gain       (gain_v),
        .out        (out),
        .out_valid  (out_valid),
        .clip       (clip),
        .busy       (busy),
        .sample_drop(sample_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_in(input int a, input int b,
                                            input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] pack_g(input int g);
        return {4{g[7:0]}};
    endfunction

    // Frame-level reference: integer sum of sample*gain, floor-divide by
    // 2^GAINFRAC, clamp to the sample range.
    function automatic void mix_ref(input logic [63:0] iv, input logic [31:0] gv,
                                    output logic signed [15:0] o, output logic c);
        longint sum = 0;
        longint r;
        for (int i = 0; i < CHANNELS; i++) begin
            logic signed [15:0] s;
            logic [7:0] g;
            s = iv[i*16 +: 16];
            g = gv[i*8 +: 8];
            sum += longint'(s) * longint'(g);
        end
        r = sum >>> GAINFRAC;
        c = 1'b0;
        if (r > 32767)       begin r = 32767;  c = 1'b1; end
        else if (r < -32768) begin r = -32768; c = 1'b1; end
        o = r[15:0];
    endfunction

    // ---------------- model state ----------------
    typedef struct {
        int                 due;
        logic signed [15:0] o;
        logic               c;
    } frame_t;

    frame_t             pend[$];
    int                 cyc     = 0;
    int                 free_at = 0;
    logic signed [15:0] m_out   = '0;
    logic               m_clip  = 1'b0;
    logic               m_valid = 1'b0;
    logic               m_drop  = 1'b0;
    logic               m_busy  = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                pend.delete();
                free_at = 0;
                m_out   = '0;
                m_clip  = 1'b0;
                m_valid = 1'b0;
                m_drop  = 1'b0;
                m_busy  = 1'b0;
            end else begin
                frame_t f;
                cyc++;
                m_valid = 1'b0;
                m_drop  = 1'b0;
                if (sample_in === 1'b1) begin
                    if (cyc >= free_at) begin
                        mix_ref(in_v, gain_v, f.o, f.c);
                        f.due   = cyc + LAT;
                        free_at = cyc + SPACING;
                        pend.push_back(f);
                    end else begin
                        m_drop = 1'b1;
                    end
                end
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    f = pend.pop_front();
                    m_out   = f.o;
                    m_clip  = f.c;
                    m_valid = 1'b1;
                end
                m_busy = (cyc < free_at - 1);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            check("cmp_out",         out,         m_out);
            check("cmp_clip",        clip,        m_clip);
            check("cmp_out_valid",   out_valid,   m_valid);
            check("cmp_busy",        busy,        m_busy);
            check("cmp_sample_drop", sample_drop, m_drop);
        end
    end

    // Single strobe; measures latency and busy length, pins literal result.
    // Inputs are scrambled right after the accepting edge.
    task automatic run_frame(input string name, input logic [63:0] iv,
                             input logic [31:0] gv, input int exp_out,
                             input int exp_clip);
        int n  = 0;
        int nb = 0;
        bit got = 0;
        @(negedge clk);
        in_v = iv; gain_v = gv; sample_in = 1'b1;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                sample_in = 1'b0;
                in_v      = ~iv;
                gain_v    = ~gv;
            end
            if (busy) nb++;
            if (out_valid) got = 1;
        end
        check({name, "_latency"}, n, LAT + 1);
        check({name, "_busy_cycles"}, nb, LAT);
        check({name, "_out"}, out, exp_out);
        check({name, "_clip"}, clip, exp_clip);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        int valids;
        int res[3];
        sample_in = 1'b0;
        in_v      = '0;
        gain_v    = '0;

        #2 rstn = 1'b0;
        armed = 1;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;

        // Idle: nothing happens without a strobe.
        valids = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) valids++;
        end
        check("idle_valids", valids, 0);
        check("idle_out", out, 0);
        check("idle_busy", busy, 0);

        run_frame("quarter", pack_in(1000, 2000, -400, 400), pack_g(16), 750, 0);
        run_frame("sat_pos", pack_in(32767, 32767, 32767, 32767), pack_g(255), 32767, 1);
        run_frame("sat_neg", pack_in(-32768, -32768, -32768, -32768), pack_g(255), -32768, 1);
        run_frame("floor_mute", pack_in(12345, -1, 12345, 12345),
                  {8'd0, 8'd0, 8'd16, 8'd0}, -1, 0);
        run_frame("unity", pack_in(3, -7, 11, 20), pack_g(64), 27, 0);

        // Overrun: second strobe two cycles after the first.
        @(negedge clk);
        in_v = pack_in(10, 20, 30, 40); gain_v = pack_g(64); sample_in = 1'b1;
        drops = 0; valids = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin sample_in = 1'b0; in_v = pack_in(9, 9, 9, 9); end
            if (n == 2) sample_in = 1'b1;
            if (n == 3) sample_in = 1'b0;
            if (sample_drop) drops++;
            if (out_valid) begin
                valids++;
                check("overrun_out", out, 100);
            end
        end
        check("overrun_drops", drops, 1);
        check("overrun_valids", valids, 1);

        // Back-to-back at the minimum spacing.
        @(negedge clk);
        in_v = pack_in(100, -200, 300, -400); gain_v = pack_g(64); sample_in = 1'b1;
        drops = 0; valids = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1 || n == 7 || n == 13) sample_in = 1'b0;
            if (n == SPACING) begin
                in_v = pack_in(1, 2, 3, 4); gain_v = pack_g(32); sample_in = 1'b1;
            end
            if (n == 2 * SPACING) begin
                in_v = pack_in(-5, 0, 0, 0); gain_v = pack_g(1); sample_in = 1'b1;
            end
            if (sample_drop) drops++;
            if (out_valid) begin
                if (valids < 3) res[valids] = int'(out);
                valids++;
            end
        end
        check("b2b_drops", drops, 0);
        check("b2b_valids", valids, 3);
        check("b2b_res0", res[0], -200);
        check("b2b_res1", res[1], 5);
        check("b2b_res2", res[2], -1);

        // Reset in the middle of ACCUM.
        @(negedge clk);
        in_v = pack_in(500, 500, 500, 500); gain_v = pack_g(64); sample_in = 1'b1;
        @(negedge clk);
        sample_in = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_out", out, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_clip", clip, 0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        valids = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) valids++;
        end
        check("rst_mid_no_valid", valids, 0);
        run_frame("after_rst", pack_in(100, 100, 100, 100), pack_g(64), 400, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mixer_n_seq.md
Name: mixer_n_seq

Overview:
Parametrised, time-multiplexed N-channel audio mixer with per-channel unsigned gain and output saturation. Successor to the fixed 4-input quarter-gain mixer. One multiply-accumulate per clock across CHANNELS inputs, triggered by a per-sample strobe. Sits between the voice and oscillator sources and the DAC/I2S output path.

Parameters:
BITSIZE, 16, sample width (signed two's complement) for each input and for the output.
CHANNELS, 4, number of input channels (>=2).
GAINBITS, 8, width of each unsigned per-channel gain.
GAINFRAC, 6, fractional bits of gain. Gain value G means G/2^GAINFRAC: 64 = 1.0 and 16 = 0.25 at defaults.

Ports:
clk  input  1  system clock, all logic on rising edge.
rstn  input  1  asynchronous active-low reset.
sample_in  input  1  one-cycle strobe: new input frame valid.
in  input  CHANNELS*BITSIZE  packed signed samples. Channel i is in[i*BITSIZE +: BITSIZE].
gain  input  CHANNELS*GAINBITS  packed unsigned gains. Channel i is gain[i*GAINBITS +: GAINBITS].
out  output  BITSIZE  signed mixed sample, registered.
out_valid  output  1  one-cycle pulse when out updates.
clip  output  1  high with out_valid if the result saturated, else 0.
busy  output  1  high while a frame is in progress.
sample_drop  output  1  one-cycle pulse when sample_in arrives while busy.

Behaviour:
- Reset (rstn low, async):
  - out=0, out_valid=0, clip=0, busy=0, sample_drop=0.
  - State=IDLE; accumulator, index and latches cleared.
  - Reset mid-frame aborts the frame with no out_valid.
- Arithmetic:
  - prod_i = in_i (signed) * {1'b0, gain_i}, giving BITSIZE+GAINBITS+1 bits, signed.
  - Accumulator width ACCW = BITSIZE+GAINBITS+1+$clog2(CHANNELS); it cannot overflow.
  - Result = acc >>> GAINFRAC (arithmetic shift, floor toward -inf), then saturated to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
  - clip=1 iff saturation changed the value.
- FSM:
  - IDLE: busy=0. On sample_in at edge k: latch all of in and gain, acc=0, idx=0, go to ACCUM.
  - ACCUM: busy=1. Each edge: acc += prod[idx]; idx++. After the edge that adds channel CHANNELS-1, go to OUTPUT. This is edges k+1 .. k+CHANNELS.
  - OUTPUT: busy=1. Edge k+CHANNELS+1: out and clip register, out_valid=1 for exactly one cycle, go to IDLE.
- Latency and throughput:
  - out_valid is high in the cycle after edge k+CHANNELS+1.
  - Minimum sample_in spacing is CHANNELS+2 cycles.
  - sample_in may be re-accepted at the edge where state has returned to IDLE, i.e. back-to-back frames.
- Input timing: in and gain are sampled only at the accepting edge; later changes do not affect the frame in progress.
- Overrun: sample_in while busy=1 is ignored; sample_drop pulses for one cycle at the next edge; the current frame completes unaffected.
- Output hold: out and clip hold their values between out_valid pulses.
- Gain 0 mutes a channel. Gain 2^GAINFRAC is unity.

Test Plan:
- Reset then idle: all outputs 0; out_valid never asserts without sample_in.
- Quarter mix: in={1000,2000,-400,400}, gain all 16, one sample_in -> out=750, clip=0, out_valid exactly 6 cycles after the strobe edge, busy high for 5 cycles.
- Saturation: all in=32767, gain=255 -> out=32767, clip=1. All in=-32768, gain=255 -> out=-32768, clip=1.
- Floor rounding and mute: in1=-1 with gain 16, other channels gain 0 with in=12345 -> out=-1, clip=0.
- Overrun and back-to-back:
  - Second strobe 2 cycles after the first -> sample_drop pulses once; first frame's result is correct.
  - Strobes spaced exactly 6 cycles apart -> every frame accepted, no sample_drop.
- Reset mid-frame: assert rstn low during ACCUM -> outputs immediately 0, no out_valid; next frame {100,100,100,100} gain 64 -> out=400.
